// File: rtl/uc_broadcast_if.sv
// -----------------------------------------------------------------------------
// uc_broadcast_if
// Bundle of the arbiter-side and engine-side signals of uc_broadcast.
//
//   in_valid / in_lit / in_ready : pop handshake with the unit-clause queue
//   conflict                     : sticky conflict level from the arbiter
//   eng_en                       : engines participating (sampled at capture)
//   eng_valid / eng_ready        : per-engine offer / FIFO-not-full
//   eng_lit                      : literal shared by all engines
//   bcast_count/busy/aborted/overflow : status
//
// Modports:
//   slave  - the broadcast block itself
//   master - the surrounding environment (queue, arbiter, engines)
// -----------------------------------------------------------------------------
interface uc_broadcast_if #(
  parameter int LIT_W      = 11,
  parameter int NUM_ENGINE = 4,
  parameter int CNT_W      = 7
);
  logic                    in_valid;
  logic signed [LIT_W-1:0] in_lit;
  logic                    in_ready;
  logic                    conflict;
  logic [NUM_ENGINE-1:0]   eng_en;
  logic [NUM_ENGINE-1:0]   eng_valid;
  logic [NUM_ENGINE-1:0]   eng_ready;
  logic signed [LIT_W-1:0] eng_lit;
  logic [CNT_W-1:0]        bcast_count;
  logic                    busy;
  logic                    aborted;
  logic                    overflow;

  modport slave (
    input  in_valid, in_lit, conflict, eng_en, eng_ready,
    output in_ready, eng_valid, eng_lit, bcast_count, busy, aborted, overflow
  );

  modport master (
    output in_valid, in_lit, conflict, eng_en, eng_ready,
    input  in_ready, eng_valid, eng_lit, bcast_count, busy, aborted, overflow
  );
endinterface

// File: rtl/uc_broadcast.sv
// -----------------------------------------------------------------------------
// uc_broadcast
// Pops one signed unit-clause literal at a time from the arbiter output queue
// and offers it to every enabled engine receive FIFO. The literal is held
// until each targeted engine has taken it; a per-engine pending mask makes
// sure a slow engine never causes a second delivery to a fast one. A conflict
// from the arbiter stops all delivery permanently (until reset).
//
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : uc_broadcast_if.slave
//          in_valid/in_lit/in_ready  queue pop handshake
//          conflict                  arbiter conflict level
//          eng_en                    participating engines, latched at capture
//          eng_valid/eng_ready       per-engine handshake
//          eng_lit                   held literal (bit-exact copy of in_lit)
//          bcast_count               literals fully delivered, saturating
//          busy                      literal held, delivery in progress
//          aborted                   sticky, conflict seen
//          overflow                  sticky, capture while count saturated
//
// All outputs are registered or decoded from state, so there is no
// combinational path from in_valid to in_ready nor from eng_ready to
// eng_valid. Peak throughput is one literal per two cycles.
// -----------------------------------------------------------------------------
module uc_broadcast #(
  parameter int LIT_W      = 11,
  parameter int NUM_ENGINE = 4,
  parameter int MAX_UC     = 64,
  parameter int CNT_W      = 7
) (
  input  logic           clk,
  input  logic           rst,
  uc_broadcast_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  // Saturating increment of the delivered-literal counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(MAX_UC)) begin
      return CNT_W'(MAX_UC);
    end
    return c + 1'b1;
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [LIT_W-1:0] r_lit;
  logic signed [LIT_W-1:0] w_lit_nxt;
  logic [NUM_ENGINE-1:0]   r_pending;
  logic [NUM_ENGINE-1:0]   w_pending_nxt;
  logic [NUM_ENGINE-1:0]   w_pending_left;
  logic [NUM_ENGINE-1:0]   w_hs;
  logic [NUM_ENGINE-1:0]   w_eng_valid;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        w_count_nxt;
  logic                    r_aborted;
  logic                    w_aborted_nxt;
  logic                    r_overflow;
  logic                    w_overflow_nxt;
  logic                    w_in_ready;

  // Output decode. in_ready is gated by rst so it reads 0 while reset is
  // held even though the state register already sits in IDLE.
  assign w_in_ready  = rst && (r_state == S_IDLE) && !bus.conflict;
  assign w_eng_valid = (r_state == S_SEND) ? r_pending : '0;
  assign w_hs        = w_eng_valid & bus.eng_ready;

  assign bus.in_ready    = w_in_ready;
  assign bus.eng_valid   = w_eng_valid;
  assign bus.eng_lit     = r_lit;
  assign bus.bcast_count = r_count;
  assign bus.busy        = (r_state == S_SEND);
  assign bus.aborted     = r_aborted;
  assign bus.overflow    = r_overflow;

  // Next-state and register-update logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_lit_nxt      = r_lit;
    w_pending_nxt  = r_pending;
    w_count_nxt    = r_count;
    w_aborted_nxt  = r_aborted;
    w_overflow_nxt = r_overflow;
    w_pending_left = r_pending & ~w_hs;

    case (r_state)
      S_IDLE: begin
        if (bus.conflict) begin
          // Conflict beats a simultaneous in_valid: nothing is captured.
          w_state_nxt   = S_ABORT;
          w_aborted_nxt = 1'b1;
        end else if (bus.in_valid) begin
          w_lit_nxt     = bus.in_lit;
          w_pending_nxt = bus.eng_en;
          if (r_count == CNT_W'(MAX_UC)) begin
            w_overflow_nxt = 1'b1;
          end
          if (bus.eng_en != '0) begin
            w_state_nxt = S_SEND;
          end else begin
            // No engine wants it: the literal counts as delivered at once.
            w_count_nxt = sat_inc(r_count);
          end
        end
      end

      S_SEND: begin
        if (bus.conflict) begin
          // Handshakes this cycle still happen on the engine side, but the
          // literal is abandoned and never counted.
          w_state_nxt   = S_ABORT;
          w_aborted_nxt = 1'b1;
          w_pending_nxt = '0;
        end else begin
          w_pending_nxt = w_pending_left;
          if (w_pending_left == '0) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = sat_inc(r_count);
          end
        end
      end

      S_ABORT: begin
        w_pending_nxt = '0;
        w_aborted_nxt = 1'b1;
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_pending_nxt = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and status registers; all cleared so outputs read 0 in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lit      <= '0;
      r_pending  <= '0;
      r_count    <= '0;
      r_aborted  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_lit      <= w_lit_nxt;
      r_pending  <= w_pending_nxt;
      r_count    <= w_count_nxt;
      r_aborted  <= w_aborted_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

endmodule

// File: tb/tb_uc_broadcast.sv
module tb_uc_broadcast;
  localparam int LIT_W      = 11;
  localparam int NUM_ENGINE = 4;
  localparam int MAX_UC     = 64;
  localparam int CNT_W      = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uc_broadcast_if #(.LIT_W(LIT_W), .NUM_ENGINE(NUM_ENGINE), .CNT_W(CNT_W)) bus();

  uc_broadcast #(
    .LIT_W(LIT_W), .NUM_ENGINE(NUM_ENGINE), .MAX_UC(MAX_UC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [LIT_W-1:0] exp_q [NUM_ENGINE][$];
  int hs_cnt [NUM_ENGINE];

  // Scoreboard: each engine handshake pops the literal expected for it.
  always @(negedge clk) begin
    logic [LIT_W-1:0] e;
    if (rst === 1'b1) begin
      for (int i = 0; i < NUM_ENGINE; i++) begin
        if (bus.eng_valid[i] === 1'b1 && bus.eng_ready[i] === 1'b1) begin
          hs_cnt[i]++;
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL deliver_eng%0d: got extra handshake lit=%h, expected none", i, bus.eng_lit);
          end else begin
            e = exp_q[i].pop_front();
            if (bus.eng_lit !== e) begin
              errors++;
              $display("FAIL deliver_eng%0d: got lit=%h, expected %h", i, bus.eng_lit, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_lit = '0; bus.conflict = 1'b0;
    bus.eng_en = '0; bus.eng_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NUM_ENGINE; i++) begin
      exp_q[i].delete();
      hs_cnt[i] = 0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Offers lit from posedge+1; returns at posedge+1 just after the capture.
  task automatic drive_capture(input logic [LIT_W-1:0] lit);
    bit done = 1'b0;
    bus.in_lit = lit; bus.in_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        for (int i = 0; i < NUM_ENGINE; i++)
          if (bus.eng_en[i]) exp_q[i].push_back(lit);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL capture_timeout: lit=%h in_ready never 1, expected capture", lit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.in_lit = 11'h155; bus.conflict = 1'b0;
    bus.eng_en = 4'hF; bus.eng_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.eng_valid !== 4'h0) begin errors++; $display("FAIL reset_eng_valid: got %b expected 0000", bus.eng_valid); end
    checks++; if (bus.eng_lit !== 11'h000) begin errors++; $display("FAIL reset_eng_lit: got %h expected 000", bus.eng_lit); end
    checks++; if (bus.bcast_count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.bcast_count); end
    checks++; if ({bus.busy, bus.aborted, bus.overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_status: got busy/aborted/overflow=%b expected 000", {bus.busy, bus.aborted, bus.overflow});
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.eng_en = 4'hF; bus.eng_ready = 4'hF;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready: got %b expected 1", bus.in_ready); end
    drive_capture(11'h005);
    checks++; if (bus.eng_valid !== 4'hF) begin errors++; $display("FAIL single_eng_valid: got %b expected 1111", bus.eng_valid); end
    checks++; if (bus.eng_lit !== 11'h005) begin errors++; $display("FAIL single_eng_lit: got %h expected 005", bus.eng_lit); end
    checks++; if ({bus.busy, bus.in_ready} !== 2'b10) begin errors++; $display("FAIL single_send_status: got busy,in_ready=%b expected 10", {bus.busy, bus.in_ready}); end
    @(posedge clk); #1;
    checks++; if ({bus.busy, bus.in_ready, bus.eng_valid} !== 6'b010000) begin
      errors++; $display("FAIL single_back_idle: got busy,in_ready,eng_valid=%b expected 010000", {bus.busy, bus.in_ready, bus.eng_valid});
    end
    checks++; if (bus.bcast_count !== 7'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", bus.bcast_count); end
    for (int i = 0; i < NUM_ENGINE; i++) begin
      checks++; if (hs_cnt[i] != 1 || exp_q[i].size() != 0) begin
        errors++; $display("FAIL single_hs_eng%0d: got %0d handshakes, %0d left, expected 1 and 0", i, hs_cnt[i], exp_q[i].size());
      end
    end
  endtask

  task automatic test_partial();
    do_reset();
    bus.eng_en = 4'hF; bus.eng_ready = 4'h0;
    drive_capture(11'h7FD);
    checks++; if (bus.eng_valid !== 4'hF) begin errors++; $display("FAIL partial_start: got %b expected 1111", bus.eng_valid); end
    bus.eng_ready = 4'b0001;
    @(posedge clk); #1;
    checks++; if ({bus.in_ready, bus.eng_valid} !== 5'b01110) begin errors++; $display("FAIL partial_step1: got in_ready,eng_valid=%b expected 01110", {bus.in_ready, bus.eng_valid}); end
    bus.eng_ready = 4'b0110;
    @(posedge clk); #1;
    checks++; if ({bus.in_ready, bus.eng_valid} !== 5'b01000) begin errors++; $display("FAIL partial_step2: got in_ready,eng_valid=%b expected 01000", {bus.in_ready, bus.eng_valid}); end
    bus.eng_ready = 4'b1000;
    @(posedge clk); #1;
    checks++; if ({bus.busy, bus.eng_valid} !== 5'b00000) begin errors++; $display("FAIL partial_done: got busy,eng_valid=%b expected 00000", {bus.busy, bus.eng_valid}); end
    checks++; if (bus.bcast_count !== 7'd1) begin errors++; $display("FAIL partial_count: got %0d expected 1", bus.bcast_count); end
    bus.eng_ready = 4'hF;
    @(posedge clk); #1;
    for (int i = 0; i < NUM_ENGINE; i++) begin
      checks++; if (hs_cnt[i] != 1 || exp_q[i].size() != 0) begin
        errors++; $display("FAIL partial_hs_eng%0d: got %0d handshakes, %0d left, expected 1 and 0", i, hs_cnt[i], exp_q[i].size());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [LIT_W-1:0] lits [3];
    logic [5:0] pat;
    int idx;
    lits[0] = 11'h007; lits[1] = 11'h7F9; lits[2] = 11'h00C;
    pat = '0; idx = 0;
    do_reset();
    bus.eng_en = 4'hF; bus.eng_ready = 4'hF;
    bus.in_valid = 1'b1; bus.in_lit = lits[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pat[c] = bus.in_ready;
      if (bus.in_ready === 1'b1 && idx < 3) begin
        for (int i = 0; i < NUM_ENGINE; i++) exp_q[i].push_back(lits[idx]);
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 3) bus.in_lit = lits[idx];
      else bus.in_valid = 1'b0;
    end
    checks++; if (pat !== 6'b010101) begin errors++; $display("FAIL b2b_ready_pattern: got %b expected 010101", pat); end
    checks++; if (bus.bcast_count !== 7'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", bus.bcast_count); end
    for (int i = 0; i < NUM_ENGINE; i++) begin
      checks++; if (hs_cnt[i] != 3 || exp_q[i].size() != 0) begin
        errors++; $display("FAIL b2b_hs_eng%0d: got %0d handshakes, %0d left, expected 3 and 0", i, hs_cnt[i], exp_q[i].size());
      end
    end
  endtask

  task automatic test_en_change();
    do_reset();
    bus.eng_en = 4'b0101; bus.eng_ready = 4'hF;
    drive_capture(11'h123);
    bus.eng_en = 4'hF;
    checks++; if (bus.eng_valid !== 4'b0101) begin errors++; $display("FAIL en_change_valid: got %b expected 0101", bus.eng_valid); end
    @(posedge clk); #1;
    checks++; if ({bus.busy, bus.bcast_count} !== {1'b0, 7'd1}) begin
      errors++; $display("FAIL en_change_done: got busy=%b count=%0d expected busy=0 count=1", bus.busy, bus.bcast_count);
    end
    checks++; if (hs_cnt[0] != 1 || hs_cnt[1] != 0 || hs_cnt[2] != 1 || hs_cnt[3] != 0) begin
      errors++; $display("FAIL en_change_hs: got %0d%0d%0d%0d expected 1010 (eng0..3)", hs_cnt[0], hs_cnt[1], hs_cnt[2], hs_cnt[3]);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    bus.eng_en = 4'hF; bus.eng_ready = 4'h0;
    drive_capture(11'h055);
    bus.conflict = 1'b1; bus.in_valid = 1'b1; bus.in_lit = 11'h0AA;
    @(posedge clk); #1;
    checks++; if ({bus.aborted, bus.busy, bus.in_ready, bus.eng_valid} !== 7'b1000000) begin
      errors++; $display("FAIL conflict_send: got aborted,busy,in_ready,eng_valid=%b expected 1000000", {bus.aborted, bus.busy, bus.in_ready, bus.eng_valid});
    end
    checks++; if (bus.bcast_count !== 7'd0) begin errors++; $display("FAIL conflict_count: got %0d expected 0", bus.bcast_count); end
    bus.eng_ready = 4'hF;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++; if ({bus.aborted, bus.busy, bus.in_ready, bus.eng_valid} !== 7'b1000000) begin
        errors++; $display("FAIL conflict_hold%0d: got %b expected 1000000", c, {bus.aborted, bus.busy, bus.in_ready, bus.eng_valid});
      end
    end
    bus.conflict = 1'b0;
    @(posedge clk); #1;
    checks++; if ({bus.aborted, bus.in_ready, bus.busy} !== 3'b100) begin
      errors++; $display("FAIL conflict_terminal: got aborted,in_ready,busy=%b expected 100", {bus.aborted, bus.in_ready, bus.busy});
    end
    checks++; if (hs_cnt[0] + hs_cnt[1] + hs_cnt[2] + hs_cnt[3] != 0) begin
      errors++; $display("FAIL conflict_no_delivery: got %0d handshakes expected 0", hs_cnt[0] + hs_cnt[1] + hs_cnt[2] + hs_cnt[3]);
    end

    // Handshake in the same cycle as conflict still completes for that engine.
    do_reset();
    bus.eng_en = 4'b0011; bus.eng_ready = 4'h0;
    drive_capture(11'h066);
    bus.eng_ready = 4'b0001; bus.conflict = 1'b1;
    @(posedge clk); #1;
    checks++; if (hs_cnt[0] != 1 || hs_cnt[1] != 0) begin
      errors++; $display("FAIL conflict_same_cycle_hs: got eng0=%0d eng1=%0d expected 1 and 0", hs_cnt[0], hs_cnt[1]);
    end
    checks++; if ({bus.aborted, bus.eng_valid, bus.bcast_count} !== {1'b1, 4'h0, 7'd0}) begin
      errors++; $display("FAIL conflict_same_cycle_state: got aborted=%b eng_valid=%b count=%0d expected 1 0000 0", bus.aborted, bus.eng_valid, bus.bcast_count);
    end

    // Conflict with in_valid in IDLE: nothing is captured.
    do_reset();
    bus.eng_en = 4'hF; bus.eng_ready = 4'hF;
    bus.conflict = 1'b1; bus.in_valid = 1'b1; bus.in_lit = 11'h011;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL idle_conflict_ready: got %b expected 0", bus.in_ready); end
    @(posedge clk); #1;
    checks++; if ({bus.aborted, bus.busy, bus.eng_valid, bus.bcast_count} !== {1'b1, 1'b0, 4'h0, 7'd0}) begin
      errors++; $display("FAIL idle_conflict_state: got aborted=%b busy=%b eng_valid=%b count=%0d expected 1 0 0000 0", bus.aborted, bus.busy, bus.eng_valid, bus.bcast_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.eng_en = 4'b0001; bus.eng_ready = 4'b0001;
    for (int k = 0; k < MAX_UC; k++) drive_capture(LIT_W'(k));
    @(posedge clk); #1;
    checks++; if ({bus.bcast_count, bus.overflow} !== {7'd64, 1'b0}) begin
      errors++; $display("FAIL ovf_before: got count=%0d overflow=%b expected 64 0", bus.bcast_count, bus.overflow);
    end
    drive_capture(11'h400);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.overflow); end
    @(posedge clk); #1;
    checks++; if ({bus.bcast_count, bus.busy} !== {7'd64, 1'b0}) begin
      errors++; $display("FAIL ovf_saturate: got count=%0d busy=%b expected 64 0", bus.bcast_count, bus.busy);
    end
    checks++; if (hs_cnt[0] != 65 || exp_q[0].size() != 0) begin
      errors++; $display("FAIL ovf_delivered: got %0d handshakes, %0d left, expected 65 and 0", hs_cnt[0], exp_q[0].size());
    end
    bus.eng_ready = 4'h0;
    drive_capture(11'h3FF);
    checks++; if ({bus.busy, bus.eng_valid} !== 5'b10001) begin
      errors++; $display("FAIL rst_mid_send_pre: got busy,eng_valid=%b expected 10001", {bus.busy, bus.eng_valid});
    end
    rst = 1'b0;
    #1;
    checks++; if ({bus.in_ready, bus.eng_valid, bus.busy, bus.aborted, bus.overflow} !== 8'h00) begin
      errors++; $display("FAIL rst_mid_send_ctrl: got %b expected 00000000", {bus.in_ready, bus.eng_valid, bus.busy, bus.aborted, bus.overflow});
    end
    checks++; if ({bus.eng_lit, bus.bcast_count} !== 18'h0) begin
      errors++; $display("FAIL rst_mid_send_data: got lit=%h count=%0d expected 000 0", bus.eng_lit, bus.bcast_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_partial();
    test_back_to_back();
    test_en_change();
    test_conflict();
    test_overflow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uc_broadcast.md
Name: uc_broadcast

Overview:
- Sits directly downstream of the unit-clause arbiter's output queue.
- Pops one signed unit-clause literal at a time and broadcasts it to all enabled engines' receive FIFOs.
- Holds each literal until every enabled engine has accepted it, tracking per-engine acceptance so slow engines do not cause duplicate delivery.
- On a conflict from the arbiter, stops all delivery and reports the abort.

Parameters:
- LIT_W, 11, literal width: sign bit (polarity) plus 10-bit variable index (UC_LENGTH=1024).
- NUM_ENGINE, 4, number of engine receive ports.
- MAX_UC, 64, maximum literals broadcast per solve; counter saturation point.
- CNT_W, 7, counter width; must hold 0..MAX_UC.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  queue has a literal.
- in_lit  in  LIT_W  literal from queue, signed.
- in_ready  out  1  block accepts in_lit this cycle (pop strobe to queue).
- conflict  in  1  arbiter conflict; level, sticky upstream.
- eng_en  in  NUM_ENGINE  engines participating; sampled at capture.
- eng_valid  out  NUM_ENGINE  per-engine offer of eng_lit.
- eng_ready  in  NUM_ENGINE  per-engine FIFO not full.
- eng_lit  out  LIT_W  broadcast literal, shared by all engines.
- bcast_count  out  CNT_W  literals fully delivered since reset.
- busy  out  1  a literal is held and not yet fully delivered.
- aborted  out  1  sticky; conflict seen.
- overflow  out  1  sticky; a literal was captured while bcast_count==MAX_UC.

Behaviour:
- Reset (rst=0, async): state=IDLE, lit_r=0, pending=0, bcast_count=0, aborted=0, overflow=0. All outputs are 0 during reset, including in_ready and eng_valid.
- Outputs are registered or decoded from state only. in_ready has no combinational path from in_valid, and eng_valid has no combinational path from eng_ready.
- FSM states: IDLE, SEND, ABORT.
- IDLE:
  - in_ready=1 unless conflict=1.
  - On in_valid && in_ready: lit_r<=in_lit and pending<=eng_en.
  - If eng_en!=0, next state is SEND. If eng_en==0, the literal is dropped, bcast_count increments, and the state stays IDLE.
- SEND:
  - in_ready=0; busy=1; eng_valid=pending; eng_lit=lit_r.
  - For each i, eng_valid[i] && eng_ready[i] clears pending[i] at the clock edge.
  - When the next value of pending is 0, return to IDLE and increment bcast_count. This covers all remaining engines accepting in the same cycle.
  - Minimum latency is 1 cycle from capture to eng_valid. Peak throughput is one literal per 2 cycles.
- eng_en changes while in SEND are ignored; pending fixes the target set at capture.
- eng_valid[i] stays asserted with lit_r stable until handshake i. It never deasserts early except on abort.
- ABORT:
  - conflict=1 in any state moves to ABORT at the next edge and sets aborted=1.
  - In ABORT: pending<=0, eng_valid=0, in_ready=0, busy=0.
  - ABORT is terminal until reset.
  - A handshake in the same cycle conflict rises still completes for that engine. The partially delivered literal is not counted.
- Counter: bcast_count saturates at MAX_UC. A capture while bcast_count==MAX_UC sets overflow. That literal is still delivered, but the count holds.
- Literal is passed bit-exact: no sign extension and no check on index range.
- Simultaneous in_valid and conflict in IDLE: conflict wins; in_ready=0 and nothing is captured.
- Reset mid-SEND: eng_valid drops immediately (async). The literal is lost; upstream re-drives after reset.

Test Plan:
- eng_en=4'b1111, eng_ready=4'b1111, in_lit=11'h005 -> eng_valid=4'b1111 with eng_lit=11'h005 one cycle after capture; IDLE next cycle; bcast_count=1.
- eng_en=4'b1111, eng_ready=4'b0001 then 4'b0110 then 4'b1000 on successive cycles, in_lit=-3 -> pending goes 1110, 1000, 0000; in_ready=0 throughout; each engine sees exactly one handshake; bcast_count=1.
- Issue 3 literals {+7,-7,+12} back-to-back with all engines ready -> in_ready pulses every other cycle; delivery order preserved; bcast_count=3.
- Capture with eng_en=4'b0101, then change eng_en to 4'b1111 during SEND with eng_ready=4'b1111 -> only eng_valid[0] and eng_valid[2] assert; done in 1 cycle.
- In SEND with eng_ready=0, assert conflict -> next cycle state=ABORT, aborted=1, eng_valid=0, in_ready=0 forever; bcast_count unchanged; in_valid held high is ignored.
- Deliver 65 literals with eng_en=4'b0001 -> bcast_count=64, overflow=1 after the 65th capture. Then pull rst low mid-SEND -> all outputs 0 immediately.
